micro_sequencer: RTL
====================

# micro_sequencer

Microprogram sequencer for the CPU control path, functionally equivalent to the Am2910 and driven by the 4-bit `SQI` field of the current microword. It sits directly upstream of the microinstruction control store. Each cycle it computes the next microaddress `A` from the microword's jump address, the selected condition, an internal loop counter and a 5-deep subroutine stack. The control store reads at `A`, and the trace monitor observes `SQI` and `A`.

## Interface

- `AW`, 12, microaddress and counter width
- `DEPTH`, 5, subroutine stack depth

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `sqi`  in  4  sequencer opcode (0 JZ … 15 TWB)
- `d`  in  AW  direct input: jump address from the pipeline, map PROM or vector source
- `cond`  in  1  selected condition, active high
- `ccen`  in  1  condition enable; when 0 the test always passes
- `ci`  in  1  incrementer carry-in; uPC ← A + ci
- `rld`  in  1  force-load the counter: R ← d, overriding the opcode's counter action
- `a`  out  AW  next microaddress (combinational)
- `pl_en`  out  1  selects the pipeline as the `d` source
- `map_en`  out  1  selects the map PROM as the `d` source
- `vect_en`  out  1  selects the vector source as the `d` source
- `full`  out  1  stack holds `DEPTH` entries

## Operation

**Definitions**
- pass = !ccen || cond.
- Z = (R == 0).
- TOS = top of stack.

**State**
- uPC (AW bits).
- R (AW bits).
- Stack: `DEPTH` × AW entries.
- SP: 0..`DEPTH`.

**Per-opcode action** (`a` / stack / R; any case not listed leaves that state unchanged)
- 0 JZ: a=0; SP←0.
- 1 CJS: pass → a=d, push uPC; fail → a=uPC.
- 2 JMAP: a=d.
- 3 CJP: pass → a=d; fail → a=uPC.
- 4 PUSH: a=uPC; push uPC; if pass, R←d.
- 5 JSRP: a = pass ? d : R; push uPC in both cases.
- 6 CJV: pass → a=d; fail → a=uPC.
- 7 JRP: a = pass ? d : R.
- 8 RFCT: !Z → a=TOS, R←R−1; Z → a=uPC, pop.
- 9 RPCT: !Z → a=d, R←R−1; Z → a=uPC.
- 10 CRTN: pass → a=TOS, pop; fail → a=uPC.
- 11 CJPP: pass → a=d, pop; fail → a=uPC.
- 12 LDCT: a=uPC; R←d.
- 13 LOOP: pass → a=uPC, pop; fail → a=TOS.
- 14 CONT: a=uPC.
- 15 TWB:
  - !Z: fail → a=TOS; pass → a=uPC, pop. R←R−1 in both cases.
  - Z: fail → a=d, pop; pass → a=uPC, pop.

**Source enables**
- Exactly one of `pl_en`/`map_en`/`vect_en` is high every cycle.
- `map_en` is high iff sqi=2.
- `vect_en` is high iff sqi=6.
- `pl_en` is high otherwise.

**Register updates**
- uPC ← a + ci every cycle (modulo 2^AW).
- `rld`=1 → R←d, overriding any decrement or load from the opcode.

**Stack boundaries**
- Push when full: overwrites TOS; SP stays at `DEPTH`.
- Pop when SP=0: no change.
- TOS with SP=0: reads 0.
- JZ clear takes priority over everything.

**Reset**
- State: uPC=0, R=0, SP=0.
- While `reset` is high: `a`=0, `pl_en`=1, `map_en`=0, `vect_en`=0, `full`=0. Inputs are ignored.
- Reset asserted mid-loop or mid-subroutine discards the stack and counter contents.

## Timing

- `a` and the source enables are purely combinational from `sqi`, `d`, `cond`, `ccen`, R, TOS and uPC. There is no registered output latency.
- uPC, R, stack and SP update on the rising `clk` edge that ends the cycle.
- A push in cycle N makes the pushed value TOS in cycle N+1.
- `full` is registered: it reflects SP after the edge.
- R decrement and the Z test use the pre-edge R. For example, RFCT with R=3 repeats 4 times: Z is observed on the 4th pass.
- First cycle after reset is released: uPC=0, so CONT yields `a`=0, then 1, 2, ….

## Test plan

- **Reset then sequential run:** reset for 10 cycles, then CONT with ci=1 → `a` = 0,1,2,3; during reset `a`=0 and `pl_en`=1.
- **Subroutine call and return:** CJS at uPC=0x010 with pass and d=0x200 → `a`=0x200; later CRTN with pass → `a`=0x011 and SP back to 0. The same CJS with fail (ccen=1, cond=0) → `a`=0x011, no push.
- **Counted loop:** LDCT d=2 at 0x020, PUSH at 0x021 (ccen=0), RFCT at 0x023 → `a` sequence 0x022,0x023,0x022,0x023,0x022,0x023,0x024; R ends at 0; SP ends at 0.
- **Stack overflow/underflow:** 6 consecutive CJS pass → `full`=1 after the 5th; the 6th overwrites TOS. 6 CRTN → returns the 6th, 4th, 3rd, 2nd, 1st addresses, then TOS=0; SP never goes negative.
- **Map/vector enables and rld override:** JMAP d=0x3A5 → `a`=0x3A5 with `map_en`=1. CJV pass → `vect_en`=1. RPCT with R=5 and rld=1, d=9 → R=9 after the edge, not 4.
- **TWB, all four cases:** R≠0 fail → `a`=TOS, R−1. R≠0 pass → uPC, pop. R=0 fail → d, pop. R=0 pass → uPC, pop.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Sequencer-side bundle: opcode, direct input and condition in; next address,
// source enables and stack-full flag out.
interface micro_sequencer_if #(
   parameter int AW = 12
);
   logic [3:0]    sqi;
   logic [AW-1:0] d;
   logic          cond;
   logic          ccen;
   logic          ci;
   logic          rld;
   logic [AW-1:0] a;
   logic          pl_en;
   logic          map_en;
   logic          vect_en;
   logic          full;

   modport master (
      output sqi, d, cond, ccen, ci, rld,
      input  a, pl_en, map_en, vect_en, full
   );

   modport slave (
      input  sqi, d, cond, ccen, ci, rld,
      output a, pl_en, map_en, vect_en, full
   );
endinterface

// File: rtl/micro_sequencer.sv
// Am2910-style microprogram sequencer: next-address mux, loop counter R,
// microprogram counter and a DEPTH-entry subroutine stack.
module micro_sequencer #(
   parameter int AW    = 12,
   parameter int DEPTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   micro_sequencer_if.slave      bus
);
   localparam int SPW = $clog2(DEPTH + 1);
   localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
   localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
   localparam logic [SPW-1:0] SP_TOP  = SPW'(DEPTH - 1);
   localparam logic [AW-1:0]  A_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0]  A_ONE   = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0]  upc_r;
   logic [AW-1:0]  r_r;
   logic [SPW-1:0] sp_r;
   logic           full_r;
   logic [AW-1:0]  stack_r [DEPTH];

   logic [AW-1:0]  a_s;
   logic [AW-1:0]  tos_s;
   logic [SPW-1:0] sp_nxt_s;
   logic [SPW-1:0] wr_idx_s;
   logic           pass_s;
   logic           z_s;
   logic           push_s;
   logic           pop_s;
   logic           clr_s;
   logic           r_load_s;
   logic           r_dec_s;

   assign pass_s = !bus.ccen || bus.cond;
   assign z_s    = (r_r == A_ZERO);

   // Top-of-stack read; an empty stack reads as zero.
   always_comb begin
      tos_s = A_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
         if (sp_r == SPW'(i + 1)) begin
            tos_s = stack_r[i];
         end else begin
            tos_s = tos_s;
         end
      end
   end

   // Opcode decode: next address plus stack and counter actions.
   always_comb begin
      a_s      = upc_r;
      push_s   = 1'b0;
      pop_s    = 1'b0;
      clr_s    = 1'b0;
      r_load_s = 1'b0;
      r_dec_s  = 1'b0;
      case (bus.sqi)
         4'd0: begin
            a_s   = A_ZERO;
            clr_s = 1'b1;
         end
         4'd1: begin
            if (pass_s) begin
               a_s    = bus.d;
               push_s = 1'b1;
            end else begin
               a_s = upc_r;
            end
         end
         4'd2: a_s = bus.d;
         4'd3, 4'd6: begin
            if (pass_s) begin
               a_s = bus.d;
            end else begin
               a_s = upc_r;
            end
         end
         4'd4: begin
            push_s   = 1'b1;
            r_load_s = pass_s;
         end
         4'd5: begin
            a_s    = pass_s ? bus.d : r_r;
            push_s = 1'b1;
         end
         4'd7: a_s = pass_s ? bus.d : r_r;
         4'd8: begin
            if (!z_s) begin
               a_s     = tos_s;
               r_dec_s = 1'b1;
            end else begin
               pop_s = 1'b1;
            end
         end
         4'd9: begin
            if (!z_s) begin
               a_s     = bus.d;
               r_dec_s = 1'b1;
            end else begin
               a_s = upc_r;
            end
         end
         4'd10: begin
            if (pass_s) begin
               a_s   = tos_s;
               pop_s = 1'b1;
            end else begin
               a_s = upc_r;
            end
         end
         4'd11: begin
            if (pass_s) begin
               a_s   = bus.d;
               pop_s = 1'b1;
            end else begin
               a_s = upc_r;
            end
         end
         4'd12: r_load_s = 1'b1;
         4'd13: begin
            if (pass_s) begin
               pop_s = 1'b1;
            end else begin
               a_s = tos_s;
            end
         end
         4'd14: a_s = upc_r;
         4'd15: begin
            // Z with a failed test exits to d; every other path but "!Z fail" pops.
            r_dec_s = !z_s;
            if (pass_s) begin
               a_s   = upc_r;
               pop_s = 1'b1;
            end else if (z_s) begin
               a_s   = bus.d;
               pop_s = 1'b1;
            end else begin
               a_s = tos_s;
            end
         end
         default: a_s = upc_r;
      endcase

      if (clr_s) begin
         sp_nxt_s = SP_ZERO;
      end else if (push_s) begin
         sp_nxt_s = (sp_r == SP_FULL) ? sp_r : sp_r + SP_ONE;
      end else if (pop_s) begin
         sp_nxt_s = (sp_r == SP_ZERO) ? sp_r : sp_r - SP_ONE;
      end else begin
         sp_nxt_s = sp_r;
      end

      if (sp_r == SP_FULL) begin
         wr_idx_s = SP_TOP;
      end else begin
         wr_idx_s = sp_r;
      end
   end

   assign bus.a       = reset ? A_ZERO : a_s;
   assign bus.map_en  = !reset && (bus.sqi == 4'd2);
   assign bus.vect_en = !reset && (bus.sqi == 4'd6);
   assign bus.pl_en   = reset || !((bus.sqi == 4'd2) || (bus.sqi == 4'd6));
   assign bus.full    = full_r && !reset;

   // uPC, loop counter and stack pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         upc_r  <= A_ZERO;
         r_r    <= A_ZERO;
         sp_r   <= SP_ZERO;
         full_r <= 1'b0;
      end else begin
         upc_r  <= a_s + {{(AW-1){1'b0}}, bus.ci};
         sp_r   <= sp_nxt_s;
         full_r <= (sp_nxt_s == SP_FULL);
         if (bus.rld || r_load_s) begin
            r_r <= bus.d;
         end else if (r_dec_s) begin
            r_r <= r_r - A_ONE;
         end else begin
            r_r <= r_r;
         end
      end
   end

   // Stack storage; contents beyond SP are never read, so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!reset && push_s && (wr_idx_s == SPW'(i))) begin
            stack_r[i] <= upc_r;
         end
      end
   end
endmodule
